// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 active-low matrix keypad one column at a time,
// debounces whole-scan results and reports a registered key code, press strobe and held level.
module keypad_scanner #(
  parameter int SCAN_TICKS     = 100000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       resetn,
  output logic [3:0] col,
  input  logic [3:0] row,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int TW = $clog2(SCAN_TICKS);
  localparam int SW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [TW-1:0] TICK_LAST  = TW'(SCAN_TICKS - 1);
  localparam logic [TW-1:0] TICK_ONE   = TW'(1'b1);
  localparam logic [SW-1:0] STABLE_MAX = SW'(DEBOUNCE_SCANS);
  localparam logic [SW-1:0] STABLE_ONE = SW'(1'b1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_MULTI   = 2'd2
  } state_t;

  // Result is {kind, code}; the code is forced to zero unless exactly one key is down
  // so that candidate comparison is a plain equality.
  function automatic logic [5:0] classify_scan(input logic [15:0] scan_n);
    logic [4:0] lows;
    logic [3:0] code;
    lows = 5'd0;
    code = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (!scan_n[4'(i)]) begin
        lows = lows + 5'd1;
        code = 4'(i);
      end else begin
        lows = lows;
      end
    end
    if (lows == 5'd0) begin
      classify_scan = {ST_IDLE, 4'd0};
    end else if (lows == 5'd1) begin
      classify_scan = {ST_PRESSED, code};
    end else begin
      classify_scan = {ST_MULTI, 4'd0};
    end
  endfunction

  logic [3:0]    row_meta_r;
  logic [3:0]    row_sync_r;
  logic [TW-1:0] tick_r;
  logic [1:0]    col_idx_r;
  logic [1:0]    col_idx_next_s;
  logic [15:0]   scan_r;
  logic          classify_r;
  logic [5:0]    result_s;
  state_t        res_kind_s;
  logic [3:0]    res_code_s;
  state_t        cand_kind_r;
  logic [3:0]    cand_code_r;
  logic [SW-1:0] stable_r;
  logic [SW-1:0] stable_next_s;
  state_t        state_r;
  logic          change_s;

  // Scan classification and next debounce values, consumed only when classify_r is set.
  always_comb begin
    col_idx_next_s = col_idx_r + 2'd1;
    result_s       = classify_scan(scan_r);
    res_kind_s     = state_t'(result_s[5:4]);
    res_code_s     = result_s[3:0];
    if ((res_kind_s == cand_kind_r) && (res_code_s == cand_code_r)) begin
      if (stable_r == STABLE_MAX) begin
        stable_next_s = STABLE_MAX;
      end else begin
        stable_next_s = stable_r + STABLE_ONE;
      end
    end else begin
      stable_next_s = STABLE_ONE;
    end
    // key_code always holds k while in PRESSED(k), so it stands in for the state's code.
    change_s = (stable_next_s == STABLE_MAX) &&
               ((res_kind_s != state_r) ||
                ((res_kind_s == ST_PRESSED) && (res_code_s != key_code)));
  end

  // Two-flop synchronizer for the asynchronous row lines.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      row_meta_r <= 4'b1111;
      row_sync_r <= 4'b1111;
    end else begin
      row_meta_r <= row;
      row_sync_r <= row_meta_r;
    end
  end

  // Column walk: capture rows on the last tick of each column, then advance.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      tick_r     <= '0;
      col_idx_r  <= 2'd0;
      col        <= 4'b1110;
      scan_r     <= 16'hFFFF;
      classify_r <= 1'b0;
    end else if (tick_r == TICK_LAST) begin
      tick_r    <= '0;
      col_idx_r <= col_idx_next_s;
      col       <= ~(4'b0001 << col_idx_next_s);
      for (int r = 0; r < 4; r++) begin
        scan_r[{2'(r), col_idx_r}] <= row_sync_r[2'(r)];
      end
      classify_r <= (col_idx_r == 2'd3);
    end else begin
      tick_r     <= tick_r + TICK_ONE;
      classify_r <= 1'b0;
    end
  end

  // Debounce candidate tracking and debounced-state FSM with its registered outputs.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cand_kind_r <= ST_IDLE;
      cand_code_r <= 4'd0;
      stable_r    <= '0;
      state_r     <= ST_IDLE;
      key_code    <= 4'd0;
      key_valid   <= 1'b0;
      key_held    <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (classify_r) begin
        cand_kind_r <= res_kind_s;
        cand_code_r <= res_code_s;
        stable_r    <= stable_next_s;
        if (change_s) begin
          state_r <= res_kind_s;
          case (res_kind_s)
            ST_PRESSED: begin
              key_code  <= res_code_s;
              key_held  <= 1'b1;
              key_valid <= 1'b1;
            end
            default: begin
              key_held <= 1'b0;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: a keypad matrix model drives the rows and a
// scan-level reference model predicts col/key_code/key_valid/key_held every cycle.
module tb_keypad_scanner;

  localparam int ST   = 4;
  localparam int DS   = 2;
  localparam int SCAN = 4 * ST;

  logic        clk     = 1'b0;
  logic        resetn  = 1'b0;
  logic [3:0]  col;
  logic [3:0]  row;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic [15:0] pressed = 16'd0;

  int errors = 0;
  int checks = 0;

  keypad_scanner #(.SCAN_TICKS(ST), .DEBOUNCE_SCANS(DS)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .col       (col),
    .row       (row),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  always #5 clk = ~clk;

  // Matrix: a row reads low when any pressed key in it sits on the driven column.
  always_comb begin
    for (int r = 0; r < 4; r++) row[r] = ~|(pressed[4*r +: 4] & ~col);
  end

  // Reference model: k counts cycles since reset exit; results are -1 NONE, -2 MULTI, else code.
  int          k      = 0;
  int          cand   = -1;
  int          cnt    = 0;
  int          deb    = -1;
  int          m_res;
  int          m_next;
  logic [15:0] p1     = 16'd0;
  logic [15:0] p2     = 16'd0;
  logic [15:0] snap   = 16'd0;
  logic        pend   = 1'b0;
  logic [3:0]  exp_col;
  logic [3:0]  exp_code  = 4'd0;
  logic        exp_valid = 1'b0;
  logic        exp_held  = 1'b0;

  function automatic int scan_result(input logic [15:0] s);
    if ($countones(s) == 0) return -1;
    if ($countones(s) > 1) return -2;
    for (int i = 0; i < 16; i++) if (s[i]) return i;
    return -2;
  endfunction

  always_comb begin
    exp_col = ~(4'b0001 << ((k / ST) % 4));
    m_res   = scan_result(snap);
    m_next  = (m_res == cand) ? ((cnt >= DS) ? DS : cnt + 1) : 1;
  end

  always @(posedge clk) begin
    if (!resetn) begin
      k <= 0; cand <= -1; cnt <= 0; deb <= -1;
      p1 <= 16'd0; p2 <= 16'd0; snap <= 16'd0; pend <= 1'b0;
      exp_code <= 4'd0; exp_valid <= 1'b0; exp_held <= 1'b0;
    end else begin
      k <= k + 1;
      p1 <= pressed;
      p2 <= p1;
      exp_valid <= 1'b0;
      pend <= 1'b0;
      if (pend) begin
        cand <= m_res;
        cnt  <= m_next;
        if (m_next == DS && m_res != deb) begin
          deb      <= m_res;
          exp_held <= (m_res >= 0);
          if (m_res >= 0) begin
            exp_code  <= 4'(m_res);
            exp_valid <= 1'b1;
          end
        end
      end
      // The synchronizer delays rows by two cycles, so the capture sees the keys of cycle k-2.
      if (k % ST == ST - 1) begin
        for (int r = 0; r < 4; r++) snap[4*r + (k / ST) % 4] <= p2[4*r + (k / ST) % 4];
        pend <= ((k / ST) % 4 == 3);
      end
    end
  end

  task automatic test_reset;
    logic [3:0] walk;
    resetn  = 1'b0;
    pressed = 16'd0;
    repeat (3) @(negedge clk);
    checks++;
    if ({col, key_code, key_valid, key_held} !== 10'b1110_0000_0_0) begin
      errors++;
      $display("FAIL reset_values got=%b want=%b", {col, key_code, key_valid, key_held}, 10'b1110_0000_0_0);
    end
    resetn = 1'b1;
    for (int i = 0; i < 3 * SCAN; i++) begin
      walk = ~(4'b0001 << ((i / ST) % 4));
      checks++;
      if ({col, key_valid, key_held} !== {walk, 2'b00}) begin
        errors++;
        $display("FAIL col_walk cycle=%0d got=%b want=%b", i, {col, key_valid, key_held}, {walk, 2'b00});
      end
      checks++;
      if ({col, key_code, key_valid, key_held} !== {exp_col, exp_code, exp_valid, exp_held}) begin
        errors++;
        $display("FAIL reset_model t=%0t got=%b want=%b", $time, {col, key_code, key_valid, key_held}, {exp_col, exp_code, exp_valid, exp_held});
      end
      @(negedge clk);
    end
  endtask

  task automatic test_single_press;
    int pulses = 0;
    int waited = 0;
    repeat ($urandom_range(0, SCAN - 1)) @(negedge clk);
    pressed = 16'd1 << 9;
    while (key_held !== 1'b1 && waited < 6 * SCAN) begin
      @(negedge clk);
      waited++;
      if (key_valid === 1'b1) pulses++;
      checks++;
      if ({col, key_code, key_valid, key_held} !== {exp_col, exp_code, exp_valid, exp_held}) begin
        errors++;
        $display("FAIL single_model t=%0t got=%b want=%b", $time, {col, key_code, key_valid, key_held}, {exp_col, exp_code, exp_valid, exp_held});
      end
    end
    checks++;
    if (key_held !== 1'b1) begin
      errors++;
      $display("FAIL single_held_timeout got=%b want=1", key_held);
    end
    for (int i = 0; i < 10 * SCAN; i++) begin
      @(negedge clk);
      if (key_valid === 1'b1) pulses++;
      checks++;
      if ({col, key_code, key_valid, key_held} !== {exp_col, exp_code, exp_valid, exp_held}) begin
        errors++;
        $display("FAIL single_hold_model t=%0t got=%b want=%b", $time, {col, key_code, key_valid, key_held}, {exp_col, exp_code, exp_valid, exp_held});
      end
    end
    checks++;
    if (pulses !== 1 || key_code !== 4'd9) begin
      errors++;
      $display("FAIL single_pulse got pulses=%0d code=%0d want pulses=1 code=9", pulses, key_code);
    end
    pressed = 16'd0;
    waited  = 0;
    while (key_held !== 1'b0 && waited < 6 * SCAN) begin
      @(negedge clk);
      waited++;
      if (key_valid === 1'b1) pulses++;
      checks++;
      if ({col, key_code, key_valid, key_held} !== {exp_col, exp_code, exp_valid, exp_held}) begin
        errors++;
        $display("FAIL release_model t=%0t got=%b want=%b", $time, {col, key_code, key_valid, key_held}, {exp_col, exp_code, exp_valid, exp_held});
      end
    end
    checks++;
    if ({key_held, key_code} !== {1'b0, 4'd9} || pulses !== 1) begin
      errors++;
      $display("FAIL release got held=%b code=%0d pulses=%0d want held=0 code=9 pulses=1", key_held, key_code, pulses);
    end
  endtask

  task automatic test_bounce;
    int key     = $urandom_range(0, 15);
    int pulses  = 0;
    int held_n  = 0;
    int waited  = 0;
    repeat ($urandom_range(0, 2) * SCAN) @(negedge clk);
    // Start where this key's column is sampled, so consecutive scans see alternating levels.
    while ((k % SCAN) != (4 * (key % 4) + 1) && waited < 2 * SCAN) begin
      @(negedge clk);
      waited++;
    end
    for (int t = 0; t < 40 + 4 * SCAN; t++) begin
      pressed = (t < 40 && ((t / 5) % 2 == 0)) ? (16'd1 << key) : 16'd0;
      @(negedge clk);
      if (key_valid === 1'b1) pulses++;
      if (key_held !== 1'b0) held_n++;
      checks++;
      if ({col, key_code, key_valid, key_held} !== {exp_col, exp_code, exp_valid, exp_held}) begin
        errors++;
        $display("FAIL bounce_model t=%0t got=%b want=%b", $time, {col, key_code, key_valid, key_held}, {exp_col, exp_code, exp_valid, exp_held});
      end
    end
    checks++;
    if (pulses !== 0 || held_n !== 0) begin
      errors++;
      $display("FAIL bounce_reject key=%0d got pulses=%0d held_cycles=%0d want 0 and 0", key, pulses, held_n);
    end
  endtask

  task automatic test_multi_key;
    int pulses = 0;
    int waited = 0;
    pressed = 16'd1 << 5;
    while (key_held !== 1'b1 && waited < 6 * SCAN) begin
      @(negedge clk);
      waited++;
      checks++;
      if ({col, key_code, key_valid, key_held} !== {exp_col, exp_code, exp_valid, exp_held}) begin
        errors++;
        $display("FAIL multi_first_model t=%0t got=%b want=%b", $time, {col, key_code, key_valid, key_held}, {exp_col, exp_code, exp_valid, exp_held});
      end
    end
    checks++;
    if ({key_held, key_code} !== {1'b1, 4'd5}) begin
      errors++;
      $display("FAIL multi_first got held=%b code=%0d want held=1 code=5", key_held, key_code);
    end
    pressed = (16'd1 << 5) | (16'd1 << 14);
    for (int i = 0; i < 6 * SCAN; i++) begin
      @(negedge clk);
      if (key_valid === 1'b1) pulses++;
      checks++;
      if ({col, key_code, key_valid, key_held} !== {exp_col, exp_code, exp_valid, exp_held}) begin
        errors++;
        $display("FAIL multi_model t=%0t got=%b want=%b", $time, {col, key_code, key_valid, key_held}, {exp_col, exp_code, exp_valid, exp_held});
      end
    end
    checks++;
    if ({key_held, key_code} !== {1'b0, 4'd5} || pulses !== 0) begin
      errors++;
      $display("FAIL multi_drop got held=%b code=%0d pulses=%0d want held=0 code=5 pulses=0", key_held, key_code, pulses);
    end
    pressed = 16'd1 << 14;
    waited  = 0;
    while (key_valid !== 1'b1 && waited < 6 * SCAN) begin
      @(negedge clk);
      waited++;
      checks++;
      if ({col, key_code, key_valid, key_held} !== {exp_col, exp_code, exp_valid, exp_held}) begin
        errors++;
        $display("FAIL multi_second_model t=%0t got=%b want=%b", $time, {col, key_code, key_valid, key_held}, {exp_col, exp_code, exp_valid, exp_held});
      end
    end
    checks++;
    if ({key_valid, key_held, key_code} !== {1'b1, 1'b1, 4'd14}) begin
      errors++;
      $display("FAIL multi_second got valid=%b held=%b code=%0d want 1 1 14", key_valid, key_held, key_code);
    end
    pressed = 16'd0;
    waited  = 0;
    while (key_held !== 1'b0 && waited < 6 * SCAN) begin
      @(negedge clk);
      waited++;
    end
    repeat (SCAN) @(negedge clk);
  endtask

  task automatic test_reset_mid_debounce;
    int waited = 0;
    int cycles = 0;
    pressed = 16'd1 << 3;
    while (!(cand == 3 && cnt == 1) && waited < 4 * SCAN) begin
      @(negedge clk);
      waited++;
      checks++;
      if ({col, key_code, key_valid, key_held} !== {exp_col, exp_code, exp_valid, exp_held}) begin
        errors++;
        $display("FAIL midrst_pre_model t=%0t got=%b want=%b", $time, {col, key_code, key_valid, key_held}, {exp_col, exp_code, exp_valid, exp_held});
      end
    end
    resetn = 1'b0;
    @(negedge clk);
    checks++;
    if ({col, key_code, key_valid, key_held} !== 10'b1110_0000_0_0) begin
      errors++;
      $display("FAIL midrst_values got=%b want=%b", {col, key_code, key_valid, key_held}, 10'b1110_0000_0_0);
    end
    resetn = 1'b1;
    while (key_valid !== 1'b1 && cycles < 6 * SCAN) begin
      @(negedge clk);
      cycles++;
      checks++;
      if ({col, key_code, key_valid, key_held} !== {exp_col, exp_code, exp_valid, exp_held}) begin
        errors++;
        $display("FAIL midrst_model t=%0t got=%b want=%b", $time, {col, key_code, key_valid, key_held}, {exp_col, exp_code, exp_valid, exp_held});
      end
    end
    checks++;
    if (cycles !== DS * SCAN + 1 || key_code !== 4'd3) begin
      errors++;
      $display("FAIL midrst_latency got cycles=%0d code=%0d want cycles=%0d code=3", cycles, key_code, DS * SCAN + 1);
    end
  endtask

  task automatic test_random;
    logic [15:0] mask;
    for (int round = 0; round < 10; round++) begin
      mask = 16'd0;
      repeat ($urandom_range(0, 2)) mask = mask | (16'd1 << $urandom_range(0, 15));
      pressed = mask;
      repeat ($urandom_range(8, 4 * SCAN)) begin
        @(negedge clk);
        checks++;
        if ({col, key_code, key_valid, key_held} !== {exp_col, exp_code, exp_valid, exp_held}) begin
          errors++;
          $display("FAIL random_model mask=%h t=%0t got=%b want=%b", mask, $time, {col, key_code, key_valid, key_held}, {exp_col, exp_code, exp_valid, exp_held});
        end
      end
    end
    pressed = 16'd0;
    for (int i = 0; i < 4 * SCAN; i++) begin
      @(negedge clk);
      checks++;
      if ({col, key_code, key_valid, key_held} !== {exp_col, exp_code, exp_valid, exp_held}) begin
        errors++;
        $display("FAIL random_tail_model t=%0t got=%b want=%b", $time, {col, key_code, key_valid, key_held}, {exp_col, exp_code, exp_valid, exp_held});
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_bounce();
    test_multi_key();
    test_reset_mid_debounce();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
